// File: rtl/l1_cache_pkg.sv
// Shared LC-3b memory-side types for the L1 cache: word/line/tag/index types, FSM state enum
// and the byte-merge helper used on write hits.
package l1_cache_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [9:0]   lc3b_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [3:0]   lc3b_c_offset;
  typedef logic [1:0]   lc3b_mem_wmask;

  typedef enum logic [1:0] {
    cs_idle,
    cs_check,
    cs_wb,
    cs_fill
  } lc3b_cache_state;

  localparam int NUM_CACHE_LINES = 8;

  function automatic lc3b_word merge_word(input lc3b_word old_w, input lc3b_word new_w,
                                          input lc3b_mem_wmask be);
    lc3b_word w;
    w[7:0]  = be[0] ? new_w[7:0]  : old_w[7:0];
    w[15:8] = be[1] ? new_w[15:8] : old_w[15:8];
    return w;
  endfunction

endpackage

// File: rtl/l1_cache_array.sv
// Eight-entry cache storage: valid/dirty/tag/line with one combinational read port and one
// synchronous write port. Only valid and dirty are cleared by reset.
module l1_cache_array
  import l1_cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  lc3b_c_index index,
  input  logic        we_line,
  input  logic        we_tag,
  input  logic        set_valid,
  input  logic        set_dirty,
  input  logic        clr_dirty,
  input  lc3b_line    line_in,
  input  lc3b_tag     tag_in,
  output logic        valid_o,
  output logic        dirty_o,
  output lc3b_tag     tag_o,
  output lc3b_line    line_o
);

  logic [NUM_CACHE_LINES-1:0] valid_q, valid_d;
  logic [NUM_CACHE_LINES-1:0] dirty_q, dirty_d;
  lc3b_tag                    tag_q  [NUM_CACHE_LINES];
  lc3b_tag                    tag_d  [NUM_CACHE_LINES];
  lc3b_line                   data_q [NUM_CACHE_LINES];
  lc3b_line                   data_d [NUM_CACHE_LINES];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (set_valid) valid_d[index] = 1'b1;
    if (set_dirty)      dirty_d[index] = 1'b1;
    else if (clr_dirty) dirty_d[index] = 1'b0;
    if (we_tag)  tag_d[index]  = tag_in;
    if (we_line) data_d[index] = line_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign valid_o = valid_q[index];
  assign dirty_o = dirty_q[index];
  assign tag_o   = tag_q[index];
  assign line_o  = data_q[index];

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1 cache (8 x 128-bit lines) for the LC-3b.
// Define L1_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module l1_cache
  import l1_cache_pkg::*;
#(
  parameter int STATS_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            mem_address,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [1:0]             mem_byte_enable,
  input  logic [15:0]            mem_wdata,
  output logic [15:0]            mem_rdata,
  output logic                   mem_resp,
  output logic [15:0]            pmem_address,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [127:0]           pmem_wdata,
  input  logic [127:0]           pmem_rdata,
  input  logic                   pmem_resp
`ifdef L1_CACHE_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] hit_count,
  output logic [STATS_WIDTH-1:0] miss_count
`endif
);

  lc3b_cache_state state_q, state_d;
  logic            pmem_read_q, pmem_read_d;
  logic            pmem_write_q, pmem_write_d;

  lc3b_c_index index;
  lc3b_tag     addr_tag;
  logic [2:0]  word_sel;
  logic        req;
  logic        hit;

  logic     we_line, we_tag, set_valid, set_dirty, clr_dirty;
  lc3b_line line_in, merged_line;
  logic     arr_valid, arr_dirty;
  lc3b_tag  arr_tag;
  lc3b_line arr_line;
  lc3b_word rd_word;

  assign index    = mem_address[6:4];
  assign word_sel = mem_address[3:1];
  assign addr_tag = {1'b0, mem_address[15:7]};
  assign req      = mem_read | mem_write;
  assign hit      = arr_valid && (arr_tag == addr_tag);

  l1_cache_array u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (index),
    .we_line   (we_line),
    .we_tag    (we_tag),
    .set_valid (set_valid),
    .set_dirty (set_dirty),
    .clr_dirty (clr_dirty),
    .line_in   (line_in),
    .tag_in    (addr_tag),
    .valid_o   (arr_valid),
    .dirty_o   (arr_dirty),
    .tag_o     (arr_tag),
    .line_o    (arr_line)
  );

  assign rd_word = arr_line[{word_sel, 4'b0000} +: 16];

  always_comb begin
    merged_line = arr_line;
    merged_line[{word_sel, 4'b0000} +: 16] = merge_word(rd_word, mem_wdata, mem_byte_enable);
  end

  // mem_read && mem_write together is a write; a dropped request finishes the pmem beat then idles.
  always_comb begin
    state_d   = state_q;
    mem_resp  = 1'b0;
    we_line   = 1'b0;
    we_tag    = 1'b0;
    set_valid = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    line_in   = merged_line;
    case (state_q)
      cs_idle: begin
        if (req) state_d = cs_check;
      end
      cs_check: begin
        if (!req) begin
          state_d = cs_idle;
        end else if (hit) begin
          mem_resp = 1'b1;
          state_d  = cs_idle;
          if (mem_write) begin
            we_line   = 1'b1;
            set_dirty = 1'b1;
          end
        end else begin
          state_d = arr_dirty ? cs_wb : cs_fill;
        end
      end
      cs_wb: begin
        if (pmem_resp) state_d = req ? cs_fill : cs_idle;
      end
      cs_fill: begin
        if (pmem_resp) begin
          if (req) begin
            line_in   = pmem_rdata;
            we_line   = 1'b1;
            we_tag    = 1'b1;
            set_valid = 1'b1;
            clr_dirty = 1'b1;
            state_d   = cs_check;
          end else begin
            state_d = cs_idle;
          end
        end
      end
      default: state_d = cs_idle;
    endcase
  end

  assign pmem_read_d  = (state_d == cs_fill);
  assign pmem_write_d = (state_d == cs_wb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= cs_idle;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
    end
  end

  assign mem_rdata    = rd_word;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_wdata   = arr_line;
  assign pmem_address = (state_q == cs_wb) ? {arr_tag[8:0], index, 4'b0000}
                                           : {mem_address[15:4], 4'b0000};

  logic unused_bits;
  assign unused_bits = ^{mem_address[0], arr_tag[9]};

`ifdef L1_CACHE_STATS_EN
  logic                   filled_q, filled_d;
  logic [STATS_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d;

  // A hit reached through a fill belongs to the miss already counted.
  always_comb begin
    filled_d = filled_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    if (state_q == cs_idle) filled_d = 1'b0;
    if (state_q == cs_fill && pmem_resp) filled_d = 1'b1;
    if (state_q == cs_check && req) begin
      if (hit) begin
        if (!filled_q && hit_q != '1) hit_d = hit_q + 1'b1;
      end else if (miss_q != '1) begin
        miss_d = miss_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filled_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      filled_q <= filled_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  localparam int unused_stats_width = STATS_WIDTH;
`endif

endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache: CPU-side driver task with a reactive physical-memory model,
// a read-data scoreboard queue and immediate-assertion checks.
module tb_l1_cache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [1:0]   mem_byte_enable = '0;
  logic [15:0]  mem_wdata = '0;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
`ifdef L1_CACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  // clock / reset
  always #5 clk = ~clk;

  l1_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
`ifdef L1_CACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  localparam logic [127:0] LINE1  = 128'h7777_6666_5555_4444_BEEF_2222_1111_0000;
  localparam logic [127:0] LINE1M = 128'h7777_6666_5555_4444_ABEF_2222_1111_0000;
  localparam logic [127:0] LINE2  = 128'hF7F7_F6F6_F5F5_F4F4_C0DE_F2F2_F1F1_F0F0;
  localparam logic [127:0] LINE3  = 128'h3737_3636_3535_3434_3333_3232_3131_3030;

  int           n_checks = 0;
  int           n_errors = 0;
  int           both_cnt = 0;
  logic [15:0]  exp_q[$];

  int           lat;
  int           wb_cnt;
  int           fill_cnt;
  logic         first_wb;
  logic [15:0]  wb_addr;
  logic [15:0]  fill_addr;
  logic [127:0] wb_data;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (pmem_read && pmem_write) both_cnt++;

  // Raise a request at a negedge; memory answers each pmem beat on its second cycle.
  // lat counts cycles including the one in which the request was raised.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [1:0] be, input logic [15:0] wd, input logic [127:0] fill);
    int   pl;
    logic done;
    wb_cnt = 0; fill_cnt = 0; first_wb = 1'b0; lat = 1; pl = 0; done = 1'b0;
    mem_address = addr; mem_read = rd; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      lat++;
      pmem_resp = 1'b0;
      if (mem_resp) begin
        done = 1'b1;
        if (rd && !wr && exp_q.size() > 0) check("rdata", mem_rdata, exp_q.pop_front());
      end else if (pmem_read || pmem_write) begin
        pl++;
        if (pl == 2) begin
          pl = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            if (wb_cnt == 0 && fill_cnt == 0) first_wb = 1'b1;
            wb_cnt++;
            wb_addr = pmem_address;
            wb_data = pmem_wdata;
          end else begin
            fill_cnt++;
            fill_addr = pmem_address;
            pmem_rdata = fill;
          end
        end
      end
    end
    check("resp_seen", done, 1'b1);
    pmem_resp = 1'b0;
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
`ifdef L1_CACHE_STATS_EN
    check("rst_hits", hit_count, 16'd0);
    check("rst_misses", miss_count, 16'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // cold read miss
    exp_q.push_back(16'hBEEF);
    access(1'b1, 1'b0, 16'h1236, 2'b11, 16'h0000, LINE1);
    check("t1_fill_cnt", fill_cnt, 1);
    check("t1_fill_addr", fill_addr, 16'h1230);
    check("t1_wb_cnt", wb_cnt, 0);
    check("t1_latency", lat, 5);
`ifdef L1_CACHE_STATS_EN
    check("t1_misses", miss_count, 16'd1);
    check("t1_hits", hit_count, 16'd0);
`endif

    // read hit, same line
    exp_q.push_back(16'h1111);
    access(1'b1, 1'b0, 16'h1232, 2'b11, 16'h0000, '0);
    check("t2_latency", lat, 2);
    check("t2_fill_cnt", fill_cnt, 0);
    check("t2_wb_cnt", wb_cnt, 0);
`ifdef L1_CACHE_STATS_EN
    check("t2_hits", hit_count, 16'd1);
`endif

    // high-byte write hit, then read back
    access(1'b0, 1'b1, 16'h1236, 2'b10, 16'hAB12, '0);
    check("t3_write_latency", lat, 2);
    exp_q.push_back(16'hABEF);
    access(1'b1, 1'b0, 16'h1236, 2'b11, 16'h0000, '0);

    // conflict miss on dirty line: writeback before fill
    exp_q.push_back(16'hC0DE);
    access(1'b1, 1'b0, 16'h12B6, 2'b11, 16'h0000, LINE2);
    check("t4_wb_cnt", wb_cnt, 1);
    check("t4_wb_first", first_wb, 1'b1);
    check("t4_wb_addr", wb_addr, 16'h1230);
    check("t4_wb_data", wb_data, LINE1M);
    check("t4_fill_cnt", fill_cnt, 1);
    check("t4_fill_addr", fill_addr, 16'h12B0);
    check("t4_latency", lat, 7);

    // byte_enable=00 write leaves data but marks the line dirty
    access(1'b0, 1'b1, 16'h12B4, 2'b00, 16'hFFFF, '0);
    check("be00_fill_cnt", fill_cnt, 0);
    exp_q.push_back(16'hF2F2);
    access(1'b1, 1'b0, 16'h12B4, 2'b11, 16'h0000, '0);
    exp_q.push_back(16'h2222);
    access(1'b1, 1'b0, 16'h1234, 2'b11, 16'h0000, LINE1M);
    check("be00_wb_cnt", wb_cnt, 1);
    check("be00_wb_addr", wb_addr, 16'h12B0);
    check("be00_wb_data", wb_data, LINE2);
`ifdef L1_CACHE_STATS_EN
    check("pre_rst_hits", hit_count, 16'd5);
    check("pre_rst_misses", miss_count, 16'd3);
`endif

    // reset while a fill is outstanding
    mem_address = 16'h1336; mem_read = 1'b1; mem_write = 1'b0; mem_byte_enable = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    check("t5_fill_started", seen, 1'b1);
    rst_n = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    check("t5_pmem_read_dropped", pmem_read, 1'b0);
    check("t5_pmem_write", pmem_write, 1'b0);
    check("t5_mem_resp", mem_resp, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef L1_CACHE_STATS_EN
    check("t5_hits", hit_count, 16'd0);
    check("t5_misses", miss_count, 16'd0);
`endif
    exp_q.push_back(16'h3333);
    access(1'b1, 1'b0, 16'h1336, 2'b11, 16'h0000, LINE3);
    check("t5_refill_cnt", fill_cnt, 1);
    check("t5_refill_addr", fill_addr, 16'h1330);
    check("t5_wb_cnt", wb_cnt, 0);

    // read and write together: performed as a write
    access(1'b1, 1'b1, 16'h1336, 2'b11, 16'h5A5A, '0);
    check("t6_latency", lat, 2);
    check("t6_fill_cnt", fill_cnt, 0);
    exp_q.push_back(16'h5A5A);
    access(1'b1, 1'b0, 16'h1336, 2'b11, 16'h0000, '0);
`ifdef L1_CACHE_STATS_EN
    check("t6_hits", hit_count, 16'd2);
    check("t6_misses", miss_count, 16'd1);
`endif

    check("pmem_exclusive", both_cnt, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
